cam_read: RTL
=============

Name: cam_read

Overview:
- Camera-side writer for the dual-port frame buffer.
- Samples the OV7670 parallel pixel bus (RGB565, two bytes per pixel) and converts each pixel to RGB444.
- Generates the buffer's write address, write data and write enable for a 160x120 frame.
- Sits between the camera pins and the frame buffer's write port. The VGA reader consumes the buffer on the other port.

Parameters:
- AW, 15, frame-buffer address width.
- DW, 12, pixel width (RGB444).
- IMG_W, 160, pixels per line.
- IMG_H, 120, lines per frame.

Ports:
- clk  in  1  camera pixel clock (pclk); also clocks the buffer write port.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  capture enable; level-sensitive.
- vsync  in  1  camera frame sync, high between frames.
- href  in  1  camera line valid, high while bytes are valid.
- px_data  in  8  camera data byte.
- mem_px_addr  out  AW  buffer write address.
- mem_px_data  out  DW  buffer write data {R[3:0],G[3:0],B[3:0]}.
- px_wr  out  1  buffer write enable, one-cycle pulse per pixel.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- short_frame  out  1  frame ended with fewer than IMG_W*IMG_H pixels; held until the next frame_done.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, byte phase 0, pixel counter 0.
- All outputs are registered.
- States:
  - IDLE -> WAIT_VS when init=1.
  - WAIT_VS: wait for vsync=1 then vsync=0. This guarantees capture starts at a frame boundary, never mid-frame. -> CAPTURE.
  - CAPTURE: pixel assembly, described below.
  - CAPTURE -> FRAME_END on a vsync rising edge (vsync=1 sampled with previous sample 0).
  - FRAME_END, one cycle: frame_done=1; short_frame=(count<IMG_W*IMG_H); counter cleared to 0. Then -> WAIT_VS if init=1, else -> IDLE.
- Edge detect: vsync registered once internally to detect edges. No input synchronizers, because camera signals are synchronous to clk.
- Byte assembly in CAPTURE, only while href=1:
  - Phase 0: latch px_data into byte1; phase <- 1.
  - Phase 1: form the pixel from byte1 and px_data (byte2); phase <- 0.
- Conversion, RGB565 to RGB444: R=byte1[7:4]; G={byte1[2:0],byte2[7]}; B=byte2[4:1].
- Write timing, latency 1:
  - At the edge sampling byte2, if count<IMG_W*IMG_H: mem_px_addr<=count, mem_px_data<=converted pixel, px_wr<=1, count<=count+1.
  - px_wr is therefore high in the cycle after byte2 is on the bus. Otherwise px_wr<=0.
- href=0 in CAPTURE: phase forced to 0. A dangling first byte is discarded, with no write. Counter unchanged.
- Overflow: pixels beyond IMG_W*IMG_H are dropped with no write. The address never reaches IMG_W*IMG_H, which is the reserved black pixel in the buffer.
- mem_px_addr and mem_px_data hold their last values when px_wr=0.
- Counter width is AW bits; the product IMG_W*IMG_H is compared at full width.
- init deasserted mid-frame: capture continues to FRAME_END, then IDLE. No partial abort.
- vsync rising while in WAIT_VS: no frame_done.
- Reset mid-frame: immediate return to reset values. The next capture waits for a full vsync cycle.
- busy=1 in WAIT_VS, CAPTURE and FRAME_END.

Decomposition:
- Package cam_pkg:
  - IMG_W, IMG_H and NPIX=IMG_W*IMG_H.
  - State encoding: IDLE, WAIT_VS, CAPTURE, FRAME_END.
  - RGB565 bit-field positions.
- One natural sub-module, cam_px_assembler: byte-phase register plus byte1 latch plus RGB565-to-444 conversion. It outputs pixel and pixel_valid; the FSM, counter and write logic stay in cam_read.

Test Plan:
- Reset: hold reset=0 with random bus activity -> px_wr, frame_done, short_frame, busy, mem_px_addr and mem_px_data all 0. Release with init=0 -> busy stays 0.
- Single-pixel conversion:
  - Bytes 0xF8,0x00 -> px_wr one cycle after byte2, addr 0, data 12'hF00.
  - Next pixel 0x07,0xE0 -> addr 1, data 12'h0F0.
  - Next pixel 0x00,0x1F -> addr 2, data 12'h00F.
- Full frame: init=1, vsync pulse, then 120 lines of 320 bytes -> exactly 19200 px_wr pulses with addr 0..19199 in order. On the next vsync rise: frame_done pulse, short_frame=0, next frame restarts at addr 0.
- Overflow: lines of 322 bytes (161 pixels) -> writes stop after 19200, last addr 19199, no write to addr 19200, frame_done still pulses, short_frame=0.
- Partial line and dangling byte: href drops after 3 bytes -> exactly one write. The next line's first pixel is assembled from fresh bytes, and addresses stay consecutive.
- Short frame and mid-capture: vsync rises after 100 pixels -> frame_done, short_frame=1. Separately, deassert init mid-frame -> frame completes, then busy=0. Separately, assert reset mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - frame geometry, capture states and RGB565 field helpers for the camera writer
package cam_pkg;

   localparam int IMG_W = 160;
   localparam int IMG_H = 120;
   localparam int NPIX  = IMG_W * IMG_H;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_VS   = 2'd1,
      CAPTURE   = 2'd2,
      FRAME_END = 2'd3
   } cam_state_t;

   // RGB565 arrives as byte1 = RRRRRGGG, byte2 = GGGBBBBB; keep the top bits of each field
   localparam int R_HI   = 7;
   localparam int R_LO   = 4;
   localparam int G1_HI  = 2;
   localparam int G1_LO  = 0;
   localparam int G2_BIT = 7;
   localparam int B_HI   = 4;
   localparam int B_LO   = 1;

   function automatic logic [11:0] rgb565_to_444(input logic [7:0] byte1, input logic [7:0] byte2);
      return {byte1[R_HI:R_LO], byte1[G1_HI:G1_LO], byte2[G2_BIT], byte2[B_HI:B_LO]};
   endfunction

endpackage

// File: rtl/cam_px_assembler.sv
// rtl/cam_px_assembler.sv - pairs camera bytes into RGB444 pixels
module cam_px_assembler
   import cam_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        href,
   input  logic [7:0]  px_data,
   output logic [11:0] pixel,
   output logic        pixel_valid
);

   logic       phase;
   logic [7:0] byte1;

   // Any gap in href (or leaving capture) drops a half-received pixel
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= 1'b0;
         byte1 <= 8'd0;
      end else if (en && href) begin
         if (!phase) begin
            byte1 <= px_data;
         end
         phase <= ~phase;
      end else begin
         phase <= 1'b0;
      end
   end

   assign pixel_valid = en & href & phase;
   assign pixel       = rgb565_to_444(byte1, px_data);

endmodule

// File: rtl/cam_read.sv
// rtl/cam_read.sv - OV7670 capture FSM driving the frame-buffer write port
module cam_read #(
   parameter int AW    = 15,
   parameter int DW    = 12,
   parameter int IMG_W = cam_pkg::IMG_W,
   parameter int IMG_H = cam_pkg::IMG_H
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          init,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    px_data,
   output logic [AW-1:0] mem_px_addr,
   output logic [DW-1:0] mem_px_data,
   output logic          px_wr,
   output logic          frame_done,
   output logic          short_frame,
   output logic          busy
);

   import cam_pkg::*;

   localparam logic [31:0] FRAME_PIX = 32'(IMG_W * IMG_H);

   cam_state_t    state;
   cam_state_t    state_nx;
   logic          vsync_q;
   logic [AW-1:0] count;
   logic [AW-1:0] count_after;
   logic [11:0]   pixel;
   logic          pixel_valid;
   logic          wr_go;
   logic          vs_rise;
   logic          vs_fall;

   cam_px_assembler u_asm (
      .clk         (clk),
      .reset       (reset),
      .en          (state == CAPTURE),
      .href        (href),
      .px_data     (px_data),
      .pixel       (pixel),
      .pixel_valid (pixel_valid)
   );

   // Camera pins share clk, so one register suffices for edge detection
   assign vs_rise     = vsync & ~vsync_q;
   assign vs_fall     = ~vsync & vsync_q;
   assign wr_go       = pixel_valid && (32'(count) < FRAME_PIX);
   assign count_after = wr_go ? count + 1'b1 : count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (init) state_nx = WAIT_VS;
         WAIT_VS:   if (vs_fall) state_nx = CAPTURE;
         CAPTURE:   if (vs_rise) state_nx = FRAME_END;
         FRAME_END: state_nx = init ? WAIT_VS : IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vsync_q     <= 1'b0;
         count       <= '0;
         mem_px_addr <= '0;
         mem_px_data <= '0;
         px_wr       <= 1'b0;
         frame_done  <= 1'b0;
         short_frame <= 1'b0;
         busy        <= 1'b0;
      end else begin
         vsync_q    <= vsync;
         px_wr      <= wr_go;
         frame_done <= (state_nx == FRAME_END);
         busy       <= (state_nx != IDLE);
         if (wr_go) begin
            mem_px_addr <= count;
            mem_px_data <= pixel;
         end
         if (state == FRAME_END) begin
            count <= '0;
         end else begin
            count <= count_after;
         end
         // Include a write landing on the same edge as the vsync rise
         if (state_nx == FRAME_END) begin
            short_frame <= (32'(count_after) < FRAME_PIX);
         end
      end
   end

endmodule
